// File: rtl/data_stream_out_pkg.sv
// Shared definitions for the output data-stream path: unpacker FSM states and
// the 64-bit FIFO word geometry.
package data_stream_out_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SETTLE,
    ST_FILL,
    ST_STREAM,
    ST_DONE
  } unpack_state_t;

  localparam int WORD_BITS = 64;

  function automatic int pixels_per_word(input int pix_bits);
    return WORD_BITS / pix_bits;
  endfunction

endpackage

// File: rtl/edge_generator.sv
// Rising-edge detector built on a 1-cycle registered copy of the input.
module edge_generator (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_reg;

  // Reset to 1 so a level that is already high out of reset is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_reg <= 1'b1;
    else        sig_reg <= sig;
  end

  assign rise = sig & ~sig_reg;

endmodule

// File: rtl/out_pixel_unpacker.sv
// Requests a frame from the upstream FIFO stage, then unpacks 64-bit words into
// PIX_BITS pixels (least-significant lane first), one per de_in cycle.
module out_pixel_unpacker
  import data_stream_out_pkg::*;
#(
  parameter int PIX_BITS = 16,
  parameter int REQ_HOLD = 4,
  parameter int SETTLE   = 16
) (
  input  logic                rclk,
  input  logic                rst_n,
  input  logic                vs_in,
  input  logic                de_in,
  input  logic [23:0]         frame_pixels,
  output logic                rd_req,
  output logic                req_end,
  output logic                rd_data_en,
  input  logic [63:0]         rd_data,
  input  logic                fifo_empty,
  output logic [PIX_BITS-1:0] pix_data,
  output logic                pix_valid,
  output logic                underflow
);

  localparam int PPW    = pixels_per_word(PIX_BITS);
  localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PPW - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(REQ_HOLD - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

  unpack_state_t       state_reg;
  logic [15:0]         hold_cnt_reg;
  logic [23:0]         frame_pixels_reg;
  logic [23:0]         pix_cnt_reg;
  logic [LANE_W-1:0]   lane_reg;
  logic [63:0]         cur_word_reg, nxt_word_reg;
  logic                cur_valid_reg, nxt_valid_reg;
  logic                rd_pend_reg, restart_reg;
  logic                rd_req_reg, req_end_reg, rd_data_en_reg;
  logic [PIX_BITS-1:0] pix_data_reg;
  logic                pix_valid_reg, underflow_reg;

  logic       vs_rise;
  logic       in_fetch, stream_de, last_pix, pop, arrive, issue;
  logic [1:0] occ;

  edge_generator u_vs_edge (
    .clk   (rclk),
    .rst_n (rst_n),
    .sig   (vs_in),
    .rise  (vs_rise)
  );

  // occ is the buffer occupancy after this cycle, counting a word landing now.
  always_comb begin
    in_fetch  = (state_reg == ST_FILL) || (state_reg == ST_STREAM);
    stream_de = (state_reg == ST_STREAM) && de_in && !vs_rise;
    last_pix  = stream_de && ((pix_cnt_reg + 24'd1) == frame_pixels_reg);
    pop       = stream_de && cur_valid_reg && (lane_reg == LAST_LANE);
    arrive    = rd_pend_reg && in_fetch;
    occ       = {1'b0, cur_valid_reg} + {1'b0, nxt_valid_reg} + {1'b0, arrive} - {1'b0, pop};
    issue     = in_fetch && !vs_rise && !last_pix && !fifo_empty && !rd_data_en_reg && (occ < 2'd2);
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      hold_cnt_reg     <= '0;
      frame_pixels_reg <= '0;
      pix_cnt_reg      <= '0;
      lane_reg         <= '0;
      cur_word_reg     <= '0;
      nxt_word_reg     <= '0;
      cur_valid_reg    <= 1'b0;
      nxt_valid_reg    <= 1'b0;
      rd_pend_reg      <= 1'b0;
      restart_reg      <= 1'b0;
      rd_req_reg       <= 1'b0;
      req_end_reg      <= 1'b0;
      rd_data_en_reg   <= 1'b0;
      pix_data_reg     <= '0;
      pix_valid_reg    <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      rd_data_en_reg <= 1'b0;
      pix_valid_reg  <= 1'b0;
      rd_pend_reg    <= rd_data_en_reg;
      if (vs_rise && state_reg != ST_IDLE) begin
        // Abort: signal frame end upstream, then restart; a word in flight is dropped.
        state_reg        <= ST_DONE;
        restart_reg      <= 1'b1;
        req_end_reg      <= 1'b1;
        rd_req_reg       <= 1'b0;
        hold_cnt_reg     <= '0;
        frame_pixels_reg <= frame_pixels;
        cur_valid_reg    <= 1'b0;
        nxt_valid_reg    <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (vs_rise) begin
              state_reg        <= ST_REQ;
              rd_req_reg       <= 1'b1;
              hold_cnt_reg     <= '0;
              frame_pixels_reg <= frame_pixels;
              underflow_reg    <= 1'b0;
            end
          end
          ST_REQ: begin
            if (hold_cnt_reg == HOLD_LAST) begin
              state_reg    <= ST_SETTLE;
              rd_req_reg   <= 1'b0;
              hold_cnt_reg <= '0;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + 16'd1;
            end
          end
          ST_SETTLE: begin
            cur_valid_reg <= 1'b0;
            nxt_valid_reg <= 1'b0;
            lane_reg      <= '0;
            pix_cnt_reg   <= '0;
            if (hold_cnt_reg == SETTLE_LAST) begin
              hold_cnt_reg <= '0;
              if (frame_pixels_reg == 24'd0) begin
                state_reg   <= ST_DONE;
                req_end_reg <= 1'b1;
                restart_reg <= 1'b0;
              end else begin
                state_reg <= ST_FILL;
              end
            end else begin
              hold_cnt_reg <= hold_cnt_reg + 16'd1;
            end
          end
          ST_FILL, ST_STREAM: begin
            rd_data_en_reg <= issue;
            // Returned word goes to whichever slot is empty after this cycle's pop.
            if (pop) begin
              cur_word_reg  <= nxt_word_reg;
              cur_valid_reg <= nxt_valid_reg;
              nxt_valid_reg <= 1'b0;
              if (arrive) begin
                if (nxt_valid_reg) begin
                  nxt_word_reg  <= rd_data;
                  nxt_valid_reg <= 1'b1;
                end else begin
                  cur_word_reg  <= rd_data;
                  cur_valid_reg <= 1'b1;
                end
              end
            end else if (arrive) begin
              if (!cur_valid_reg) begin
                cur_word_reg  <= rd_data;
                cur_valid_reg <= 1'b1;
              end else begin
                nxt_word_reg  <= rd_data;
                nxt_valid_reg <= 1'b1;
              end
            end
            if (state_reg == ST_FILL) begin
              if (cur_valid_reg) state_reg <= ST_STREAM;
            end else if (stream_de) begin
              pix_valid_reg <= 1'b1;
              pix_cnt_reg   <= pix_cnt_reg + 24'd1;
              if (cur_valid_reg) begin
                pix_data_reg <= cur_word_reg[lane_reg*PIX_BITS +: PIX_BITS];
                lane_reg     <= (lane_reg == LAST_LANE) ? '0 : lane_reg + 1'b1;
              end else begin
                pix_data_reg  <= '0;
                underflow_reg <= 1'b1;
              end
              if (last_pix) begin
                state_reg    <= ST_DONE;
                req_end_reg  <= 1'b1;
                hold_cnt_reg <= '0;
                restart_reg  <= 1'b0;
              end
            end
          end
          ST_DONE: begin
            if (hold_cnt_reg == HOLD_LAST) begin
              req_end_reg  <= 1'b0;
              hold_cnt_reg <= '0;
              if (restart_reg) begin
                state_reg     <= ST_REQ;
                rd_req_reg    <= 1'b1;
                underflow_reg <= 1'b0;
                restart_reg   <= 1'b0;
              end else begin
                state_reg <= ST_IDLE;
              end
            end else begin
              hold_cnt_reg <= hold_cnt_reg + 16'd1;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign rd_req     = rd_req_reg;
  assign req_end    = req_end_reg;
  assign rd_data_en = rd_data_en_reg;
  assign pix_data   = pix_data_reg;
  assign pix_valid  = pix_valid_reg;
  assign underflow  = underflow_reg;

endmodule
